alu_rs_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the single ALU.
//  - Accepts decoded AluInstr from instruction decode and holds it until both

---
 rtl/alu_rs_scheduler_pkg.sv | 56 +++++
 rtl/alu_rs_scheduler_checker.sv | 26 ++
 rtl/alu_rs_scheduler_picker.sv | 28 ++
 rtl/alu_rs_scheduler.sv | 123 ++++++++++++
 tb/tb_alu_rs_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared ALU instruction and reservation-station types plus the tag-match
// wakeup helpers used by every station.
package alu_rs_scheduler_pkg;

    typedef logic [15:0] w16;
    typedef logic [31:0] w32;

    typedef struct packed {
        w16 hi;
        w16 tag;
    } TagField;

    // A waiting source carries its producer tag; a valid one carries its data.
    typedef union packed {
        w32      data;
        TagField t;
    } SrcContent;

    typedef struct packed {
        logic      valid;
        SrcContent content;
    } Source;

    typedef struct packed {
        logic [3:0] op;
        w16         dest;
        Source      src1;
        Source      src2;
    } AluInstr;

    typedef struct packed {
        logic    valid;
        AluInstr instr;
    } RsEntry;

    function automatic Source wake_src(Source s, logic en, w16 tag, w32 data);
        Source r;
        r = s;
        if (en && !s.valid && (s.content.t.tag == tag)) begin
            r.valid        = 1'b1;
            r.content.data = data;
        end else begin
            r = s;
        end
        return r;
    endfunction

    function automatic AluInstr wake_instr(AluInstr x, logic en, w16 tag, w32 data);
        AluInstr r;
        r      = x;
        r.src1 = wake_src(x.src1, en, tag, data);
        r.src2 = wake_src(x.src2, en, tag, data);
        return r;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_checker.sv
// Invariant checks for the ALU reservation station.
module alu_rs_scheduler_checker
    import alu_rs_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                       clock,
    input logic                       reset,
    input logic [$clog2(DEPTH+1)-1:0] occupancy,
    input logic                       issue_en,
    input AluInstr                    issue_msg,
    input logic                       accept,
    input logic                       in_reject
);
    localparam int CNT_W = $clog2(DEPTH+1);

    a_occupancy_bound: assert property (@(posedge clock) disable iff (reset)
        occupancy <= CNT_W'(DEPTH));

    a_issue_sources_valid: assert property (@(posedge clock) disable iff (reset)
        issue_en |-> (issue_msg.src1.valid && issue_msg.src2.valid));

    a_no_accept_when_full: assert property (@(posedge clock) disable iff (reset)
        accept |-> !in_reject);

endmodule

// File: rtl/alu_rs_scheduler_picker.sv
// Oldest-ready picker: the lowest-index set bit of the ready vector wins.
module rs_oldest_ready_picker #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         ready,
    output logic [DEPTH-1:0]         grant,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(DEPTH);

    // Scan from slot 0 upward so the first hit is the oldest ready entry.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !any) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                any      = 1'b1;
            end else begin
                grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: age-ordered compacting array with writeback wakeup
// and oldest-ready issue over an en/reject handshake.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flash,
    input  logic                       in_en,
    input  AluInstr                    in_msg,
    output logic                       in_reject,
    input  logic                       wb_en,
    input  w16                         wb_tag,
    input  w32                         wb_data,
    output logic                       issue_en,
    output AluInstr                    issue_msg,
    input  logic                       issue_reject,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    RsEntry           entries_r [DEPTH];
    RsEntry           ext_s     [DEPTH+1];
    RsEntry           next_s    [DEPTH];
    logic [CNT_W-1:0] occupancy_r;
    logic [CNT_W-1:0] occupancy_next_s;
    logic [CNT_W-1:0] wr_slot_s;
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] grant_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             any_ready_s;
    logic             accept_s;
    logic             issue_fire_s;
    AluInstr          in_woken_s;

    // Readiness looks only at registered state, so a wakeup issues a cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = entries_r[i].valid & entries_r[i].instr.src1.valid
                       & entries_r[i].instr.src2.valid;
        end
    end

    rs_oldest_ready_picker #(.DEPTH(DEPTH)) u_picker (
        .ready (ready_s),
        .grant (grant_s),
        .idx   (pick_idx_s),
        .any   (any_ready_s)
    );

    // Handshake decodes and the one-hot issue mux.
    always_comb begin
        in_reject    = (occupancy_r == CNT_W'(DEPTH));
        issue_en     = any_ready_s & ~flash;
        accept_s     = in_en & ~in_reject & ~flash;
        issue_fire_s = issue_en & ~issue_reject;
        issue_msg    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_msg = issue_msg
                      | ({$bits(AluInstr){issue_en & grant_s[i]}} & entries_r[i].instr);
        end
    end

    assign occupancy = occupancy_r;

    // Next array: close the issued gap, wake every slot, then append the new entry.
    always_comb begin
        ext_s[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ext_s[i] = entries_r[i];
        end
        wr_slot_s        = occupancy_r - CNT_W'(issue_fire_s);
        in_woken_s       = wake_instr(in_msg, wb_en, wb_tag, wb_data);
        occupancy_next_s = occupancy_r + CNT_W'(accept_s) - CNT_W'(issue_fire_s);
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire_s && (i >= int'(pick_idx_s))) begin
                next_s[i] = ext_s[i+1];
            end else begin
                next_s[i] = ext_s[i];
            end
            next_s[i].instr = wake_instr(next_s[i].instr, wb_en, wb_tag, wb_data);
            if (accept_s && (CNT_W'(i) == wr_slot_s)) begin
                next_s[i] = {1'b1, in_woken_s};
            end else begin
                next_s[i] = next_s[i];
            end
        end
    end

    // State register; flash clears the station and overrides all same-cycle events.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupancy_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (flash) begin
            occupancy_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            occupancy_r <= occupancy_next_s;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= next_s[i];
            end
        end
    end

    alu_rs_scheduler_checker #(.DEPTH(DEPTH)) u_checker (
        .clock     (clock),
        .reset     (reset),
        .occupancy (occupancy_r),
        .issue_en  (issue_en),
        .issue_msg (issue_msg),
        .accept    (accept_s),
        .in_reject (in_reject)
    );

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: queue-based reference model predicts
// issues; a separate monitor pops and compares whatever the DUT presents.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset, flash, in_en, wb_en, issue_reject;
    logic       in_reject, issue_en;
    AluInstr    in_msg, issue_msg;
    w16         wb_tag;
    w32         wb_data;
    logic [2:0] occupancy;

    int      n_checks = 0;
    int      n_fail   = 0;
    AluInstr model_q[$];
    AluInstr exp_q[$];

    alu_rs_scheduler #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .flash        (flash),
        .in_en        (in_en),
        .in_msg       (in_msg),
        .in_reject    (in_reject),
        .wb_en        (wb_en),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .issue_en     (issue_en),
        .issue_msg    (issue_msg),
        .issue_reject (issue_reject),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic Source m_wake(Source s, logic en, w16 t, w32 d);
        Source r;
        r = s;
        if (en && !s.valid && s.content.t.tag == t) begin
            r.valid        = 1'b1;
            r.content.data = d;
        end
        return r;
    endfunction

    function automatic AluInstr m_wake_i(AluInstr x, logic en, w16 t, w32 d);
        AluInstr r;
        r      = x;
        r.src1 = m_wake(x.src1, en, t, d);
        r.src2 = m_wake(x.src2, en, t, d);
        return r;
    endfunction

    function automatic AluInstr mk(logic [3:0] op, w16 dest, logic v1, w32 c1, logic v2, w32 c2);
        AluInstr r;
        r.op                = op;
        r.dest              = dest;
        r.src1.valid        = v1;
        r.src1.content.data = c1;
        r.src2.valid        = v2;
        r.src2.content.data = c2;
        return r;
    endfunction

    function automatic AluInstr rand_instr();
        logic v1, v2;
        w32   c1, c2;
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        c1 = v1 ? $urandom : {16'h0000, 16'($urandom_range(0, 7))};
        c2 = v2 ? $urandom : {16'h0000, 16'($urandom_range(0, 7))};
        return mk(4'($urandom), 16'($urandom), v1, c1, v2, c2);
    endfunction

    // One cycle: drive, check state-level outputs, predict the issue, advance the model.
    task automatic step(input logic f, input logic ie, input AluInstr im, input logic we,
                        input w16 wt, input w32 wd, input logic ir);
        int  idx;
        logic full;
        logic exp_en;
        @(negedge clock);
        flash = f; in_en = ie; in_msg = im; wb_en = we; wb_tag = wt; wb_data = wd;
        issue_reject = ir;
        #1;
        full = (model_q.size() == DEPTH);
        chk("occupancy", 128'(occupancy), 128'(model_q.size()));
        chk("in_reject", 128'(in_reject), 128'(full));
        idx = -1;
        foreach (model_q[k]) begin
            if (idx < 0 && model_q[k].src1.valid && model_q[k].src2.valid) idx = k;
        end
        exp_en = (idx >= 0) && !f;
        chk("issue_en", 128'(issue_en), 128'(exp_en));
        if (exp_en) exp_q.push_back(model_q[idx]);
        if (f) begin
            model_q.delete();
        end else begin
            foreach (model_q[k]) model_q[k] = m_wake_i(model_q[k], we, wt, wd);
            if (exp_en && !ir) model_q.delete(idx);
            if (ie && !full) model_q.push_back(m_wake_i(im, we, wt, wd));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 16'h0, 32'h0, 1'b0);
    endtask

    // Monitor: every presented instruction must match the oldest expected issue.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                if (issue_en) begin
                    if (exp_q.size() == 0) chk("unexpected_issue", 128'(issue_msg), 128'(0));
                    else chk("issue_msg", 128'(issue_msg), 128'(exp_q.pop_front()));
                end else begin
                    chk("idle_msg_zero", 128'(issue_msg), 128'(0));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flash = 1'b0; in_en = 1'b0; in_msg = '0; wb_en = 1'b0;
        wb_tag = 16'h0; wb_data = 32'h0; issue_reject = 1'b0;
        #1;
        chk("reset_occupancy", 128'(occupancy), 128'(0));
        chk("reset_issue_en", 128'(issue_en), 128'(0));
        chk("reset_in_reject", 128'(in_reject), 128'(0));
        chk("reset_issue_msg", 128'(issue_msg), 128'(0));
        @(negedge clock);
        reset = 1'b0;

        // A ready, held by two rejects, then taken.
        step(1'b0, 1'b1, mk(4'h1, 16'hA000, 1'b1, 32'h11, 1'b1, 32'h22), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 16'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 16'h0, 32'h0, 1'b1);
        idle(2);

        // B waits on tag 5, C is ready and overtakes it; then B wakes.
        step(1'b0, 1'b1, mk(4'h2, 16'hB000, 1'b0, 32'h0000_0005, 1'b1, 32'h33), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h3, 16'hC000, 1'b1, 32'h44, 1'b1, 32'h55), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'h0005, 32'hDEADBEEF, 1'b0);
        idle(2);

        // Fill with waiting entries, offer a fifth, wake slot 2.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, mk(4'h4, 16'(i), 1'b0, 32'(16'h10 + 16'(i)), 1'b1, 32'h66), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h5, 16'hE000, 1'b0, 32'h20, 1'b1, 32'h77), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h5, 16'hE000, 1'b0, 32'h20, 1'b1, 32'h77), 1'b1, 16'h0012, 32'hCAFE0012, 1'b0);
        step(1'b0, 1'b1, mk(4'h5, 16'hE000, 1'b0, 32'h20, 1'b1, 32'h77), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h5, 16'hE001, 1'b0, 32'h21, 1'b1, 32'h78), 1'b0, 16'h0, 32'h0, 1'b0);

        // Flash while full, with accept and a matching wakeup in the same cycle.
        step(1'b1, 1'b1, mk(4'h6, 16'hF000, 1'b1, 32'h1, 1'b1, 32'h2), 1'b1, 16'h0010, 32'h1234, 1'b0);
        idle(2);

        // Accept and issue together at occupancy 2.
        step(1'b0, 1'b1, mk(4'h7, 16'h7000, 1'b0, 32'h30, 1'b1, 32'h3), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h8, 16'h8000, 1'b1, 32'h4, 1'b1, 32'h5), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, mk(4'h9, 16'h9000, 1'b0, 32'h31, 1'b1, 32'h6), 1'b0, 16'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'h0031, 32'h0BAD0031, 1'b0);
        idle(2);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 32'h0, 1'b0);

        // Asynchronous reset with three waiting entries.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, mk(4'hA, 16'(i), 1'b0, 32'h100, 1'b0, 32'h101), 1'b0, 16'h0, 32'h0, 1'b0);
        @(negedge clock);
        in_en = 1'b0; wb_en = 1'b0; flash = 1'b0; issue_reject = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_occupancy", 128'(occupancy), 128'(0));
        chk("midreset_issue_en", 128'(issue_en), 128'(0));
        model_q.delete();
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b1, mk(4'hB, 16'hB100, 1'b1, 32'h9, 1'b1, 32'hA), 1'b0, 16'h0, 32'h0, 1'b0);
        idle(2);

        // Randomized traffic with a small tag space so wakeups hit often.
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 60), rand_instr(),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 99) < 30));
        end
        idle(3);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0, 32'h0, 1'b0);
        idle(1);
        #2;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
